// File: rtl/ge_wnaf_recoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : ge_wnaf_recoder_if
//  Description : Request / digit-stream bundle for the wNAF scalar recoder.
//                master : drives start/scalar, observes status and digit writes
//                slave  : the recoder itself
//    start        request pulse, accepted while busy=0
//    scalar       NCH packed scalars, channel c at [c*NBITS +: NBITS]
//    busy         digits are being produced
//    done         one-cycle pulse after the final digit write
//    slide_we     shared digit write strobe
//    slide_waddr  digit index (weight 2^index)
//    slide_din    NCH packed signed digits, channel c at [c*DW +: DW]
//  Revision    : 1.0  initial release
// ============================================================================
interface ge_wnaf_recoder_if #(
    parameter int NBITS = 256,
    parameter int NCH   = 2,
    parameter int DW    = 8,
    parameter int AW    = $clog2(NBITS + 1)
);
    logic                  start;
    logic [NCH*NBITS-1:0]  scalar;
    logic                  busy;
    logic                  done;
    logic                  slide_we;
    logic [AW-1:0]         slide_waddr;
    logic [NCH*DW-1:0]     slide_din;

    modport master (
        output start, scalar,
        input  busy, done, slide_we, slide_waddr, slide_din
    );

    modport slave (
        input  start, scalar,
        output busy, done, slide_we, slide_waddr, slide_din
    );
endinterface
`default_nettype wire

// File: rtl/ge_wnaf_recoder.sv
`default_nettype none
// ============================================================================
//  Module      : ge_wnaf_recoder
//  Description : Recodes NCH scalars in lockstep into signed width-WIN NAF
//                digits, one digit per cycle per channel, streamed into the
//                slide digit RAM write ports. Every run writes all NBITS+1
//                entries, so the RAM never needs clearing.
//  Ports       : clk, rst (sync, active high)
//                bus (slave modport): start/scalar in; busy, done,
//                slide_we, slide_waddr, slide_din out (all registered)
//  Revision    : 1.0  initial release
// ============================================================================
module ge_wnaf_recoder #(
    parameter int NBITS = 256,
    parameter int WIN   = 5,
    parameter int NCH   = 2,
    parameter int DW    = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    ge_wnaf_recoder_if.slave    bus
);

    localparam int NDIG = NBITS + 1;
    localparam int AW   = $clog2(NDIG);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [AW-1:0] c_LAST_IDX = AW'(NDIG - 1);

    generate
        if (WIN < 2 || WIN > DW) begin : g_bad_win
            $error("ge_wnaf_recoder: WIN must lie in 2..DW");
        end
    endgenerate

    logic [0:0]          r_state;
    logic [NBITS:0]      r_k [NCH];   // remaining value incl. carry bit
    logic [AW-1:0]       r_idx;
    logic                r_busy;
    logic                r_done;
    logic                r_we;
    logic [AW-1:0]       r_waddr;
    logic [NCH*DW-1:0]   r_din;

    logic [DW-1:0]       w_d     [NCH];
    logic [NBITS:0]      w_knext [NCH];

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_ch
            logic [WIN-1:0] w_m;
            logic [NBITS:0] w_half_d;

            assign w_m = r_k[c][WIN-1:0];

            // For odd k the digit is simply the low window read as a
            // WIN-bit two's complement number: m >= 2^(WIN-1) maps to m-2^WIN.
            assign w_d[c] = r_k[c][0] ? DW'($signed(w_m)) : '0;

            // (k - d) >> 1 without the wide intermediate: with k and d both
            // odd, (k-d)/2 = floor(k/2) - floor(d/2), and floor(d/2) is the
            // arithmetic shift of the signed window, i.e. its top WIN-1 bits.
            assign w_half_d   = r_k[c][0] ? (NBITS+1)'($signed(w_m[WIN-1:1])) : '0;
            assign w_knext[c] = (r_k[c] >> 1) - w_half_d;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_din   <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_k[c] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_we   <= 1'b0;
                    // The first IDLE edge after a run is the one that retires
                    // the final write, so the strobe doubles as the done cue.
                    r_done <= r_we;
                    if (bus.start) begin
                        for (int c = 0; c < NCH; c++) begin
                            r_k[c] <= {1'b0, bus.scalar[c*NBITS +: NBITS]};
                        end
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_we    <= 1'b1;
                    r_waddr <= r_idx;
                    for (int c = 0; c < NCH; c++) begin
                        r_din[c*DW +: DW] <= w_d[c];
                        r_k[c]            <= w_knext[c];
                    end
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == c_LAST_IDX) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.slide_we    = r_we;
    assign bus.slide_waddr = r_waddr;
    assign bus.slide_din   = r_din;

endmodule
`default_nettype wire

// File: tb/tb_ge_wnaf_recoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ge_wnaf_recoder
//  Description : Self-checking bench for ge_wnaf_recoder. Directed vectors
//                with known digit sets, start-while-busy, start-in-done,
//                mid-run reset and random scalars checked by reconstruction
//                and wNAF digit invariants through a scoreboard queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ge_wnaf_recoder;

    localparam int NBITS  = 256;
    localparam int WIN    = 5;
    localparam int NCH    = 2;
    localparam int DW     = 8;
    localparam int NDIG   = NBITS + 1;
    localparam int AW     = $clog2(NDIG);
    localparam int N_RAND = 150;
    localparam int LIMIT  = 400;

    typedef struct {
        logic [NBITS-1:0] s0, s1;
        int               a0a, a0b, a1a, a1b;   // nonzero digit positions, -1 = none
        logic [DW-1:0]    v0a, v0b, v1a, v1b;
        bit               has_exp;
    } vec_t;

    typedef struct {
        vec_t v;
        int   acc_cyc;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ge_wnaf_recoder_if #(.NBITS(NBITS), .NCH(NCH), .DW(DW)) bus ();

    ge_wnaf_recoder #(.NBITS(NBITS), .WIN(WIN), .NCH(NCH), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            wr_cnt   = 0;
    int            busy_cnt = 0;
    int            n_done   = 0;
    bit            addr_bad = 1'b0;
    logic [DW-1:0] dig [NCH][NDIG];
    sb_t           q[$];

    function automatic vec_t mk(input logic [NBITS-1:0] s0, input logic [NBITS-1:0] s1,
                                input int a0a, input logic [DW-1:0] v0a,
                                input int a0b, input logic [DW-1:0] v0b,
                                input int a1a, input logic [DW-1:0] v1a,
                                input int a1b, input logic [DW-1:0] v1b);
        vec_t v;
        v.s0 = s0; v.s1 = s1;
        v.a0a = a0a; v.v0a = v0a; v.a0b = a0b; v.v0b = v0b;
        v.a1a = a1a; v.v1a = v1a; v.a1b = a1b; v.v1b = v1b;
        v.has_exp = 1'b1;
        return v;
    endfunction

    function automatic logic [NBITS-1:0] rnd256();
        logic [NBITS-1:0] a, b;
        for (int w = 0; w < NBITS/32; w++) begin
            a[w*32 +: 32] = $urandom;
            b[w*32 +: 32] = $urandom;
        end
        case ($urandom_range(0, 3))
            0: return a;
            1: return a & b;
            2: return a | b;
            default: return {{(NBITS-32){1'b0}}, a[31:0]};
        endcase
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        v = mk(rnd256(), rnd256(), -1, 0, -1, 0, -1, 0, -1, 0);
        v.has_exp = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [259:0] act, input logic [259:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic check_run(input sb_t e);
        chk("write_count", wr_cnt, NDIG);
        chk("addr_sequence_bad", addr_bad, 0);
        chk("busy_cycles", busy_cnt, NDIG);
        chk("done_latency", cyc - e.acc_cyc, NDIG + 1);
        for (int c = 0; c < NCH; c++) begin
            logic [NBITS-1:0]  sc;
            logic signed [259:0] acc;
            logic [DW-1:0]     ex [NDIG];
            bit                ok;
            int                nbad;
            int                aa, ab;
            logic [DW-1:0]     va, vb;
            sc = (c == 0) ? e.v.s0 : e.v.s1;
            acc = '0;
            ok  = 1'b1;
            for (int i = 0; i < NDIG; i++) begin
                logic signed [DW-1:0] d;
                d = $signed(dig[c][i]);
                acc = acc + ($signed(260'(d)) <<< i);
                if (d != 0) begin
                    if (d[0] == 1'b0) ok = 1'b0;
                    if (d > 15 || d < -15) ok = 1'b0;
                    for (int j = 1; j < WIN; j++) begin
                        if (i + j < NDIG && dig[c][i+j] != '0) ok = 1'b0;
                    end
                end
            end
            if (dig[c][NDIG-1] != 8'h00 && dig[c][NDIG-1] != 8'h01) ok = 1'b0;
            chk($sformatf("reconstruct_ch%0d", c), acc, {4'b0, sc});
            chk($sformatf("invariants_ch%0d", c), ok, 1);
            if (e.v.has_exp) begin
                aa = (c == 0) ? e.v.a0a : e.v.a1a;
                ab = (c == 0) ? e.v.a0b : e.v.a1b;
                va = (c == 0) ? e.v.v0a : e.v.v1a;
                vb = (c == 0) ? e.v.v0b : e.v.v1b;
                for (int i = 0; i < NDIG; i++) ex[i] = '0;
                if (aa >= 0) ex[aa] = va;
                if (ab >= 0) ex[ab] = vb;
                nbad = 0;
                for (int i = 0; i < NDIG; i++) begin
                    if (dig[c][i] !== ex[i]) nbad++;
                end
                chk($sformatf("digit_mismatches_ch%0d", c), nbad, 0);
            end
        end
    endtask

    // One clock: sample #1 after the edge, collect writes, score on done.
    task automatic step();
        sb_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.slide_we) begin
            if (bus.slide_waddr !== AW'(wr_cnt)) addr_bad = 1'b1;
            if (wr_cnt < NDIG) begin
                for (int c = 0; c < NCH; c++) dig[c][wr_cnt] = bus.slide_din[c*DW +: DW];
            end
            wr_cnt++;
        end
        if (bus.busy) busy_cnt++;
        if (bus.done) begin
            n_done++;
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                check_run(e);
            end
            wr_cnt   = 0;
            busy_cnt = 0;
            addr_bad = 1'b0;
        end
    endtask

    task automatic kick(input vec_t v, input bit push);
        sb_t e;
        bus.scalar = {v.s1, v.s0};
        bus.start  = 1'b1;
        step();
        bus.start  = 1'b0;
        if (push) begin
            e.v = v;
            e.acc_cyc = cyc;
            q.push_back(e);
        end
    endtask

    task automatic wait_done();
        int n, d0;
        n  = 0;
        d0 = n_done;
        while (n_done == d0 && n < LIMIT) begin
            step();
            n++;
        end
        chk("done_timeout", (n_done == d0), 0);
    endtask

    task automatic wait_writes(input int k);
        int n;
        n = 0;
        while (wr_cnt < k && n < LIMIT) begin
            step();
            n++;
        end
        chk("write_wait_timeout", (wr_cnt < k), 0);
    endtask

    vec_t tbl [6];

    initial begin
        logic [NBITS-1:0] ones;
        ones = '1;
        tbl[0] = mk('0, '0,          -1, 8'h00, -1, 8'h00,  -1, 8'h00, -1, 8'h00);
        tbl[1] = mk(1, 'h1F,          0, 8'h01, -1, 8'h00,   0, 8'hFF,  5, 8'h01);
        tbl[2] = mk(ones, 7,          0, 8'hFF, 256, 8'h01,  0, 8'h07, -1, 8'h00);
        tbl[3] = mk('h10, 'h19,       4, 8'h01, -1, 8'h00,   0, 8'hF9,  5, 8'h01);
        tbl[4] = mk('h0F, 'h11,       0, 8'h0F, -1, 8'h00,   0, 8'hF1,  5, 8'h01);
        tbl[5] = mk(ones ^ (ones >> 1), 'h10_0000,
                                     255, 8'h01, -1, 8'h00, 20, 8'h01, -1, 8'h00);

        bus.start  = 1'b0;
        bus.scalar = '0;
        rst = 1'b1;
        repeat (3) step();
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        chk("reset_we", bus.slide_we, 0);
        chk("reset_waddr", bus.slide_waddr, 0);
        chk("reset_din", bus.slide_din, 0);
        rst = 1'b0;
        step();

        // Directed vectors, each launched in the done cycle of the previous.
        for (int i = 0; i < 6; i++) begin
            kick(tbl[i], 1'b1);
            wait_done();
        end

        // start while busy is ignored; start in the done cycle is accepted.
        kick(tbl[3], 1'b1);
        wait_writes(50);
        bus.scalar = {tbl[2].s1, tbl[2].s0};
        bus.start  = 1'b1;
        step();
        bus.start  = 1'b0;
        wait_done();
        kick(tbl[1], 1'b1);
        wait_done();

        // Mid-run reset aborts without a done pulse.
        kick(rnd_vec(), 1'b1);
        wait_writes(101);
        rst = 1'b1;
        step();
        chk("abort_we", bus.slide_we, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        rst = 1'b0;
        q.delete();
        wr_cnt   = 0;
        busy_cnt = 0;
        addr_bad = 1'b0;
        repeat (300) step();
        kick(mk(1, 0, 0, 8'h01, -1, 8'h00, -1, 8'h00, -1, 8'h00), 1'b1);
        wait_done();

        for (int i = 0; i < N_RAND; i++) begin
            kick(rnd_vec(), 1'b1);
            wait_done();
        end

        repeat (3) step();
        chk("scoreboard_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
